// File: rtl/inst_fetcher.sv
// inst_fetcher: fetches one instruction at a time from the I-cache, decodes it
// into fetched-op queue fields, predicts the next PC statically and pushes under back-pressure.
`default_nettype none

module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req_valid,
  output logic [31:0] ic_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_inst,
  output logic        inst_out_valid,
  output logic [4:0]  op_out,
  output logic [4:0]  rd_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [31:0] imm_out,
  output logic        branch_out,
  output logic        ls_out,
  output logic        use_imm_out,
  output logic        jalr_out,
  output logic [31:0] addr_out,
  input  logic        foq_full,
  input  logic        predict_fail,
  input  logic [31:0] correct_pc,
  input  logic        jalr_done,
  input  logic [31:0] jalr_target
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_PUSH  = 3'd2,
    S_JWAIT = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  localparam logic [4:0] OP_LUI   = 5'd0;
  localparam logic [4:0] OP_AUIPC = 5'd1;
  localparam logic [4:0] OP_JAL   = 5'd2;
  localparam logic [4:0] OP_JALR  = 5'd3;
  localparam logic [4:0] OP_ADD   = 5'd18;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        ic_req_q;
  logic        out_valid_q;
  logic [4:0]  op_q, rd_q, rs1_q, rs2_q;
  logic [31:0] imm_q, addr_q;
  logic        branch_q, ls_q, use_imm_q, jalr_q;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;

  assign opcode = ic_inst[6:0];
  assign f_rd   = ic_inst[11:7];
  assign funct3 = ic_inst[14:12];
  assign f_rs1  = ic_inst[19:15];
  assign f_rs2  = ic_inst[24:20];
  assign funct7 = ic_inst[31:25];

  assign imm_i  = {{20{ic_inst[31]}}, ic_inst[31:20]};
  assign imm_s  = {{20{ic_inst[31]}}, ic_inst[31:25], ic_inst[11:7]};
  assign imm_b  = {{19{ic_inst[31]}}, ic_inst[31], ic_inst[7], ic_inst[30:25], ic_inst[11:8], 1'b0};
  assign imm_j  = {{11{ic_inst[31]}}, ic_inst[31], ic_inst[19:12], ic_inst[20], ic_inst[30:21], 1'b0};
  assign imm_u  = {ic_inst[31:12], 12'h000};
  assign imm_sh = {27'd0, ic_inst[24:20]};

  logic [4:0]  dec_op_d, dec_rd_d, dec_rs1_d, dec_rs2_d;
  logic [31:0] dec_imm_d;
  logic        dec_br_d, dec_ls_d, dec_ui_d, dec_jr_d, dec_ok_d;

  always_comb begin
    dec_op_d  = OP_ADD;
    dec_rd_d  = 5'd0;
    dec_rs1_d = 5'd0;
    dec_rs2_d = 5'd0;
    dec_imm_d = 32'd0;
    dec_br_d  = 1'b0;
    dec_ls_d  = 1'b0;
    dec_ui_d  = 1'b1;
    dec_jr_d  = 1'b0;
    dec_ok_d  = 1'b1;
    case (opcode)
      7'h37: begin dec_op_d = OP_LUI;   dec_rd_d = f_rd; dec_imm_d = imm_u; end
      7'h17: begin dec_op_d = OP_AUIPC; dec_rd_d = f_rd; dec_imm_d = imm_u; end
      7'h6F: begin dec_op_d = OP_JAL;   dec_rd_d = f_rd; dec_imm_d = imm_j; end
      7'h67: begin
        dec_op_d  = OP_JALR;
        dec_rd_d  = f_rd;
        dec_rs1_d = f_rs1;
        dec_imm_d = imm_i;
        dec_jr_d  = 1'b1;
        dec_ok_d  = (funct3 == 3'd0);
      end
      7'h63: begin
        dec_rs1_d = f_rs1;
        dec_rs2_d = f_rs2;
        dec_imm_d = imm_b;
        dec_br_d  = 1'b1;
        dec_ui_d  = 1'b0;
        case (funct3)
          3'd0:    dec_op_d = 5'd4;
          3'd1:    dec_op_d = 5'd5;
          3'd4:    dec_op_d = 5'd6;
          3'd5:    dec_op_d = 5'd7;
          3'd6:    dec_op_d = 5'd8;
          3'd7:    dec_op_d = 5'd9;
          default: dec_ok_d = 1'b0;
        endcase
      end
      7'h03: begin
        dec_rd_d  = f_rd;
        dec_rs1_d = f_rs1;
        dec_imm_d = imm_i;
        dec_ls_d  = 1'b1;
        case (funct3)
          3'd0:    dec_op_d = 5'd10;
          3'd1:    dec_op_d = 5'd11;
          3'd2:    dec_op_d = 5'd12;
          3'd4:    dec_op_d = 5'd13;
          3'd5:    dec_op_d = 5'd14;
          default: dec_ok_d = 1'b0;
        endcase
      end
      7'h23: begin
        dec_rs1_d = f_rs1;
        dec_rs2_d = f_rs2;
        dec_imm_d = imm_s;
        dec_ls_d  = 1'b1;
        case (funct3)
          3'd0:    dec_op_d = 5'd15;
          3'd1:    dec_op_d = 5'd16;
          3'd2:    dec_op_d = 5'd17;
          default: dec_ok_d = 1'b0;
        endcase
      end
      7'h13: begin
        dec_rd_d  = f_rd;
        dec_rs1_d = f_rs1;
        dec_imm_d = imm_i;
        case (funct3)
          3'd0: dec_op_d = 5'd18;
          3'd2: dec_op_d = 5'd21;
          3'd3: dec_op_d = 5'd22;
          3'd4: dec_op_d = 5'd23;
          3'd6: dec_op_d = 5'd26;
          3'd7: dec_op_d = 5'd27;
          3'd1: begin
            dec_op_d  = 5'd20;
            dec_imm_d = imm_sh;
            dec_ok_d  = (funct7 == 7'h00);
          end
          default: begin
            dec_op_d  = (funct7 == 7'h20) ? 5'd25 : 5'd24;
            dec_imm_d = imm_sh;
            dec_ok_d  = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
        endcase
      end
      7'h33: begin
        dec_rd_d  = f_rd;
        dec_rs1_d = f_rs1;
        dec_rs2_d = f_rs2;
        dec_ui_d  = 1'b0;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0:    dec_op_d = 5'd18;
            3'd1:    dec_op_d = 5'd20;
            3'd2:    dec_op_d = 5'd21;
            3'd3:    dec_op_d = 5'd22;
            3'd4:    dec_op_d = 5'd23;
            3'd5:    dec_op_d = 5'd24;
            3'd6:    dec_op_d = 5'd26;
            default: dec_op_d = 5'd27;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
          dec_op_d = 5'd19;
        end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
          dec_op_d = 5'd25;
        end else begin
          dec_ok_d = 1'b0;
        end
      end
      default: dec_ok_d = 1'b0;
    endcase
    // Anything not recognised collapses to ADDI x0,x0,0.
    if (!dec_ok_d) begin
      dec_op_d  = OP_ADD;
      dec_rd_d  = 5'd0;
      dec_rs1_d = 5'd0;
      dec_rs2_d = 5'd0;
      dec_imm_d = 32'd0;
      dec_br_d  = 1'b0;
      dec_ls_d  = 1'b0;
      dec_ui_d  = 1'b1;
      dec_jr_d  = 1'b0;
    end
  end

  // Static prediction: JAL and backward branches taken, everything else falls through.
  logic [31:0] npc_d;
  assign npc_d = (op_q == OP_JAL || (branch_q && imm_q[31])) ? pc_q + imm_q : pc_q + 32'd4;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ic_req_q    <= 1'b0;
      out_valid_q <= 1'b0;
      op_q        <= 5'd0;
      rd_q        <= 5'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      imm_q       <= 32'd0;
      addr_q      <= 32'd0;
      branch_q    <= 1'b0;
      ls_q        <= 1'b0;
      use_imm_q   <= 1'b0;
      jalr_q      <= 1'b0;
    end else if (rdy_in) begin
      if (predict_fail) begin
        pc_q        <= correct_pc;
        out_valid_q <= 1'b0;
        if (state_q == S_WAIT && !ic_resp_valid) begin
          state_q  <= S_FLUSH;
          ic_req_q <= 1'b0;
        end else begin
          state_q  <= S_WAIT;
          ic_req_q <= 1'b1;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q  <= S_WAIT;
            ic_req_q <= 1'b1;
          end
          S_WAIT: begin
            if (ic_resp_valid) begin
              op_q        <= dec_op_d;
              rd_q        <= dec_rd_d;
              rs1_q       <= dec_rs1_d;
              rs2_q       <= dec_rs2_d;
              imm_q       <= dec_imm_d;
              branch_q    <= dec_br_d;
              ls_q        <= dec_ls_d;
              use_imm_q   <= dec_ui_d;
              jalr_q      <= dec_jr_d;
              addr_q      <= pc_q;
              state_q     <= S_PUSH;
              ic_req_q    <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
          S_PUSH: begin
            if (!foq_full) begin
              out_valid_q <= 1'b0;
              pc_q        <= npc_d;
              if (jalr_q) begin
                state_q <= S_JWAIT;
              end else begin
                state_q  <= S_WAIT;
                ic_req_q <= 1'b1;
              end
            end
          end
          S_JWAIT: begin
            if (jalr_done) begin
              pc_q     <= jalr_target;
              state_q  <= S_WAIT;
              ic_req_q <= 1'b1;
            end
          end
          S_FLUSH: begin
            if (ic_resp_valid) begin
              state_q  <= S_WAIT;
              ic_req_q <= 1'b1;
            end
          end
          default: begin
            state_q     <= S_IDLE;
            ic_req_q    <= 1'b0;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ic_req_valid   = ic_req_q;
  assign ic_addr        = pc_q;
  assign inst_out_valid = out_valid_q;
  assign op_out         = op_q;
  assign rd_out         = rd_q;
  assign rs1_out        = rs1_q;
  assign rs2_out        = rs2_q;
  assign imm_out        = imm_q;
  assign branch_out     = branch_q;
  assign ls_out         = ls_q;
  assign use_imm_out    = use_imm_q;
  assign jalr_out       = jalr_q;
  assign addr_out       = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: randomized bench; the bench encodes instructions from known fields,
// queues the expected push, and a monitor compares every push the DUT presents.
`default_nettype none

module tb_inst_fetcher;
  logic        clk = 1'b0;
  logic        rst_n, rdy_in;
  logic        ic_req_valid, ic_resp_valid;
  logic [31:0] ic_addr, ic_inst;
  logic        inst_out_valid;
  logic [4:0]  op_out, rd_out, rs1_out, rs2_out;
  logic [31:0] imm_out, addr_out;
  logic        branch_out, ls_out, use_imm_out, jalr_out;
  logic        foq_full, predict_fail, jalr_done;
  logic [31:0] correct_pc, jalr_target;

  always #5 clk = ~clk;

  inst_fetcher #(.RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy_in),
    .ic_req_valid(ic_req_valid), .ic_addr(ic_addr),
    .ic_resp_valid(ic_resp_valid), .ic_inst(ic_inst),
    .inst_out_valid(inst_out_valid), .op_out(op_out), .rd_out(rd_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .imm_out(imm_out),
    .branch_out(branch_out), .ls_out(ls_out), .use_imm_out(use_imm_out),
    .jalr_out(jalr_out), .addr_out(addr_out), .foq_full(foq_full),
    .predict_fail(predict_fail), .correct_pc(correct_pc),
    .jalr_done(jalr_done), .jalr_target(jalr_target)
  );

  typedef struct {
    logic [4:0]  op, rd, rs1, rs2;
    logic [31:0] imm;
    logic        br, ls, ui, jr;
    logic [31:0] addr;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          force_full = 0;
  bit          mon_en = 1'b0;
  bit          no_freeze = 1'b1;
  logic [31:0] exp_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic exp_t mk(input logic [4:0] op, rd, rs1, rs2, input logic [31:0] imm,
                              input logic br, ls, ui, jr);
    exp_t e;
    e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.br = br; e.ls = ls; e.ui = ui; e.jr = jr; e.addr = 32'h0;
    return e;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input exp_t e);
    if (e.op == 5'd2 || (e.br && e.imm[31])) return pc + e.imm;
    return pc + 32'd4;
  endfunction

  // Build an instruction word from chosen fields; expected fields come from the choice.
  task automatic gen(output logic [31:0] inst, output exp_t e);
    logic [2:0]  bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0]  lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  af3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic [6:0]  bad [5] = '{7'h0B, 7'h2B, 7'h0F, 7'h73, 7'h5B};
    int          sel = $urandom_range(0, 29);
    logic [31:0] r = $urandom;
    logic [4:0]  rd = 5'($urandom), rs1 = 5'($urandom), rs2 = 5'($urandom);
    logic [11:0] i12 = r[11:0];
    logic [31:0] si = {{20{i12[11]}}, i12};
    logic [20:0] j = {r[20:1], 1'b0};
    logic [12:0] b = {r[12:1], 1'b0};
    logic [2:0]  f3;
    logic [6:0]  f7;
    if (sel <= 1) begin
      inst = {r[31:12], rd, (sel == 0) ? 7'h37 : 7'h17};
      e = mk(5'(sel), rd, 0, 0, {r[31:12], 12'h0}, 0, 0, 1, 0);
    end else if (sel == 2) begin
      inst = {j[20], j[10:1], j[11], j[19:12], rd, 7'h6F};
      e = mk(2, rd, 0, 0, {{11{j[20]}}, j}, 0, 0, 1, 0);
    end else if (sel == 3) begin
      inst = {i12, rs1, 3'd0, rd, 7'h67};
      e = mk(3, rd, rs1, 0, si, 0, 0, 1, 1);
    end else if (sel <= 9) begin
      f3 = bf3[sel-4];
      inst = {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'h63};
      e = mk(5'(sel), 0, rs1, rs2, {{19{b[12]}}, b}, 1, 0, 0, 0);
    end else if (sel <= 14) begin
      f3 = lf3[sel-10];
      inst = {i12, rs1, f3, rd, 7'h03};
      e = mk(5'(sel), rd, rs1, 0, si, 0, 1, 1, 0);
    end else if (sel <= 17) begin
      f3 = 3'(sel - 15);
      inst = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'h23};
      e = mk(5'(sel), 0, rs1, rs2, si, 0, 1, 1, 0);
    end else if (sel <= 27) begin
      f3 = af3[sel-18];
      f7 = (sel == 19 || sel == 25) ? 7'h20 : 7'h00;
      if (sel == 19 || $urandom_range(0, 1) == 0) begin
        inst = {f7, rs2, rs1, f3, rd, 7'h33};
        e = mk(5'(sel), rd, rs1, rs2, 0, 0, 0, 0, 0);
      end else if (sel == 20 || sel == 24 || sel == 25) begin
        inst = {f7, rs2, rs1, f3, rd, 7'h13};
        e = mk(5'(sel), rd, rs1, 0, {27'd0, rs2}, 0, 0, 1, 0);
      end else begin
        inst = {i12, rs1, f3, rd, 7'h13};
        e = mk(5'(sel), rd, rs1, 0, si, 0, 0, 1, 0);
      end
    end else begin
      inst = {r[31:7], bad[$urandom_range(0, 4)]};
      e = mk(18, 0, 0, 0, 0, 0, 0, 1, 0);
    end
  endtask

  // Advance to the next negedge such that whatever is driven now is sampled once with rdy high.
  task automatic step();
    bit r;
    do begin
      r = no_freeze || ($urandom_range(0, 7) != 0);
      rdy_in = r;
      @(negedge clk);
    end while (!r);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 200; i++) begin
      if (ic_req_valid) return;
      step();
    end
    chk("req_timeout", 0, 1);
    finish_run();
  endtask

  // mode 0: normal response; 1: predict_fail while outstanding then late response; 2: both at once.
  task automatic do_fetch(input logic [31:0] inst, input exp_t e, input int mode,
                          input logic [31:0] cpc, input logic [31:0] jt, input int hold);
    exp_t x;
    int   lat = $urandom_range(1, 3);
    wait_req();
    chk("ic_addr", ic_addr, exp_pc);
    for (int i = 0; i < lat; i++) begin
      chk("req_held", ic_req_valid, 1);
      if (i == 0 && $urandom_range(0, 3) == 0) begin
        jalr_done = 1'b1;
        jalr_target = $urandom;
      end
      step();
      jalr_done = 1'b0;
    end
    if (mode == 0) begin
      ic_resp_valid = 1'b1;
      ic_inst = inst;
      x = e;
      x.addr = exp_pc;
      sbq.push_back(x);
      step();
      ic_resp_valid = 1'b0;
      ic_inst = $urandom;
      if (hold > 0) force_full = hold;
      exp_pc = next_pc(exp_pc, e);
      if (e.jr) begin
        for (int i = 0; i < 200 && inst_out_valid; i++) step();
        chk("jalr_left_push", inst_out_valid, 0);
        for (int i = $urandom_range(0, 3); i > 0; i--) begin
          chk("jwait_no_req", ic_req_valid, 0);
          step();
        end
        chk("jwait_no_req", ic_req_valid, 0);
        jalr_done = 1'b1;
        jalr_target = jt;
        step();
        jalr_done = 1'b0;
        exp_pc = jt;
      end
    end else if (mode == 1) begin
      predict_fail = 1'b1;
      correct_pc = cpc;
      step();
      predict_fail = 1'b0;
      for (int i = $urandom_range(0, 2); i >= 0; i--) begin
        chk("flush_no_req", ic_req_valid, 0);
        if (i > 0) step();
      end
      ic_resp_valid = 1'b1;
      ic_inst = inst;
      step();
      ic_resp_valid = 1'b0;
      exp_pc = cpc;
    end else begin
      predict_fail = 1'b1;
      correct_pc = cpc;
      ic_resp_valid = 1'b1;
      ic_inst = inst;
      step();
      predict_fail = 1'b0;
      ic_resp_valid = 1'b0;
      exp_pc = cpc;
    end
  endtask

  task automatic cmp_push(input exp_t e);
    chk("op", op_out, e.op);
    chk("rd", rd_out, e.rd);
    chk("rs1", rs1_out, e.rs1);
    chk("rs2", rs2_out, e.rs2);
    chk("imm", imm_out, e.imm);
    chk("branch", branch_out, e.br);
    chk("ls", ls_out, e.ls);
    chk("use_imm", use_imm_out, e.ui);
    chk("jalr", jalr_out, e.jr);
    chk("addr", addr_out, e.addr);
  endtask

  // Queue side: drives foq_full and checks every cycle a push is offered.
  initial begin
    bit full;
    foq_full = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (force_full > 0) begin
          full = 1'b1;
          force_full--;
        end else begin
          full = ($urandom_range(0, 3) == 0);
        end
        foq_full = full;
        if (inst_out_valid) begin
          chk("no_req_in_push", ic_req_valid, 0);
          if (sbq.size() == 0) begin
            chk("stale_push", 1, 0);
          end else begin
            cmp_push(sbq[0]);
            if (!full && rdy_in) void'(sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    chk("watchdog", 0, 1);
    finish_run();
  end

  initial begin
    logic [31:0] inst, t;
    exp_t        e;
    int          r;
    rst_n = 1'b0; rdy_in = 1'b1; ic_resp_valid = 1'b0; ic_inst = 32'h0;
    predict_fail = 1'b0; correct_pc = 32'h0; jalr_done = 1'b0; jalr_target = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req", ic_req_valid, 0);
    chk("rst_ic_addr", ic_addr, 32'h0);
    chk("rst_valid", inst_out_valid, 0);
    cmp_push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("req_idle_after_reset", ic_req_valid, 0);
    mon_en = 1'b1;
    exp_pc = 32'h0;

    do_fetch(32'h00500093, mk(18, 1, 0, 0, 5, 0, 0, 1, 0), 0, 0, 0, 0);
    do_fetch(32'h00500093, mk(18, 1, 0, 0, 5, 0, 0, 1, 0), 1, 32'h10, 0, 0);
    do_fetch(32'hFE000EE3, mk(4, 0, 0, 0, 32'hFFFFFFFC, 1, 0, 0, 0), 0, 0, 0, 0);
    do_fetch(32'h00000013, mk(18, 0, 0, 0, 0, 0, 0, 1, 0), 2, 32'h20, 0, 0);
    do_fetch(32'h008000EF, mk(2, 1, 0, 0, 8, 0, 0, 1, 0), 0, 0, 0, 5);
    do_fetch(32'h00000013, mk(18, 0, 0, 0, 0, 0, 0, 1, 0), 1, 32'h100, 0, 0);
    do_fetch(32'h00000013, mk(18, 0, 0, 0, 0, 0, 0, 1, 0), 1, 32'h40, 0, 0);
    do_fetch(32'h00008067, mk(3, 0, 1, 0, 0, 0, 0, 1, 1), 0, 0, 32'h80, 0);

    no_freeze = 1'b0;
    for (int n = 0; n < 300; n++) begin
      gen(inst, e);
      r = $urandom_range(0, 99);
      t = $urandom;
      t[1:0] = 2'b00;
      do_fetch(inst, e, (r < 85) ? 0 : (r < 93) ? 1 : 2, t, {t[31:4], 4'h8},
               ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : 0);
    end
    wait_req();
    chk("ic_addr", ic_addr, exp_pc);
    chk("sb_drained", sbq.size(), 0);

    // Asynchronous reset in the middle of a held push.
    no_freeze = 1'b1;
    do_fetch(32'h00500093, mk(18, 1, 0, 0, 5, 0, 0, 1, 0), 0, 0, 0, 50);
    step();
    chk("held_valid", inst_out_valid, 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", inst_out_valid, 0);
    chk("async_rst_req", ic_req_valid, 0);
    chk("async_rst_ic_addr", ic_addr, 32'h0);
    chk("async_rst_op", op_out, 0);
    chk("async_rst_imm", imm_out, 0);
    chk("async_rst_rd", rd_out, 0);
    finish_run();
  end

endmodule

`default_nettype wire
